// File: rtl/picomips_pkg.sv
// Shared types and defaults for the picoMIPS control path.
package picomips_pkg;

    typedef enum logic [1:0] {
        RUN          = 2'd0,
        WAIT_PRESS   = 2'd1,
        WAIT_RELEASE = 2'd2,
        HALTED       = 2'd3
    } pcseq_state_t;

    localparam int DB_COUNT_DFLT = 50000;

endpackage

// File: rtl/sw_debounce.sv
// Two-flop synchroniser for the raw SW8 switch, with an optional debounce counter.
// Build macro PC_DEBOUNCE_EN adds the counter; otherwise sw8_clean is the synchronised level.
module sw_debounce #(
    parameter int DB_COUNT = 50000,
    parameter int DB_WIDTH = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic sw_raw,
    output logic sw8_clean
);

    logic sync_meta;
    logic sw8_sync;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_meta <= 1'b0;
            sw8_sync  <= 1'b0;
        end else begin
            sync_meta <= sw_raw;
            sw8_sync  <= sync_meta;
        end
    end

`ifdef PC_DEBOUNCE_EN
    localparam logic [DB_WIDTH-1:0] CNT_LAST = DB_WIDTH'(DB_COUNT - 1);

    logic [DB_WIDTH-1:0] cnt;
    logic                clean_q;

    // A new level must differ for DB_COUNT consecutive edges before it is accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            clean_q <= 1'b0;
        end else if (sw8_sync == clean_q) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt     <= '0;
            clean_q <= sw8_sync;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign sw8_clean = clean_q;
`else
    assign sw8_clean = sw8_sync;

    if (DB_COUNT < 1 || DB_WIDTH < 1) begin : g_db_params_unused
    end
`endif

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: advances, waits on an SW8 press/release handshake, or halts.
// Build macro PC_DEBOUNCE_EN enables switch debouncing inside sw_debounce.
module pc_sequencer
    import picomips_pkg::*;
#(
    parameter int P_SIZE    = 4,
    parameter int PROG_LAST = 2**P_SIZE - 1,
    parameter int DB_COUNT  = DB_COUNT_DFLT,
    parameter int DB_WIDTH  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              SW8,
    input  logic              wait_sw,
    input  logic              halt,
    output logic [P_SIZE-1:0] PCout,
    output logic              sw8_clean,
    output logic              stall,
    output logic [1:0]        state
);

    localparam logic [P_SIZE-1:0] PC_LAST = P_SIZE'(PROG_LAST);

    pcseq_state_t      cur_state;
    pcseq_state_t      nxt_state;
    logic              pc_adv;
    logic [P_SIZE-1:0] pc_q;
    logic [P_SIZE-1:0] pc_inc;

    sw_debounce #(
        .DB_COUNT (DB_COUNT),
        .DB_WIDTH (DB_WIDTH)
    ) u_sw_debounce (
        .clk       (clk),
        .reset     (reset),
        .sw_raw    (SW8),
        .sw8_clean (sw8_clean)
    );

    assign pc_inc = (pc_q == PC_LAST) ? '0 : pc_q + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            cur_state <= RUN;
            pc_q      <= '0;
        end else begin
            cur_state <= nxt_state;
            if (pc_adv) begin
                pc_q <= pc_inc;
            end
        end
    end

    // wait_sw/halt only matter in RUN; the held PC keeps the instruction stable elsewhere.
    always_comb begin
        nxt_state = cur_state;
        pc_adv    = 1'b0;
        case (cur_state)
            RUN: begin
                if (halt) begin
                    nxt_state = HALTED;
                end else if (wait_sw) begin
                    nxt_state = WAIT_PRESS;
                end else begin
                    pc_adv = 1'b1;
                end
            end
            WAIT_PRESS: begin
                if (sw8_clean) begin
                    nxt_state = WAIT_RELEASE;
                end
            end
            WAIT_RELEASE: begin
                if (!sw8_clean) begin
                    nxt_state = RUN;
                    pc_adv    = 1'b1;
                end
            end
            default: begin
                nxt_state = cur_state;
            end
        endcase
    end

    always_comb begin
        stall = (cur_state != RUN) | halt | wait_sw;
        state = cur_state;
        PCout = pc_q;
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: vector table, hand-written switch sequences, and randomized run vs. a reference model.
module tb_pc_sequencer;

    localparam int DB = 4;
`ifdef PC_DEBOUNCE_EN
    localparam int LAT = 2 + DB;
    localparam bit DEB = 1'b1;
`else
    localparam int LAT = 2;
    localparam bit DEB = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sw8 = 1'b0;
    logic       wait_sw = 1'b0;
    logic       halt = 1'b0;
    logic [3:0] pc;
    logic       clean;
    logic       stall;
    logic [1:0] state;
    logic [3:0] pc11;
    logic       clean11;
    logic       stall11;
    logic [1:0] state11;

    pc_sequencer #(.P_SIZE(4), .PROG_LAST(15), .DB_COUNT(DB), .DB_WIDTH(16)) dut (
        .clk(clk), .reset(reset), .SW8(sw8), .wait_sw(wait_sw), .halt(halt),
        .PCout(pc), .sw8_clean(clean), .stall(stall), .state(state)
    );

    pc_sequencer #(.P_SIZE(4), .PROG_LAST(11), .DB_COUNT(DB), .DB_WIDTH(16)) dut11 (
        .clk(clk), .reset(reset), .SW8(sw8), .wait_sw(1'b0), .halt(1'b0),
        .PCout(pc11), .sw8_clean(clean11), .stall(stall11), .state(state11)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: abstract program counter, mode number, and switch history.
    int m_pc = 0;
    int m_st = 0;
    int m_clean = 0;
    int m_run = 0;
    int m11 = 0;
    bit pipe[$] = '{1'b0, 1'b0};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_edge();
        bit s;
        if (reset) begin
            m_pc = 0; m_st = 0; m_clean = 0; m_run = 0; m11 = 0;
            pipe = '{1'b0, 1'b0};
        end else begin
            s = pipe[0];
            case (m_st)
                0: if (halt) m_st = 3;
                   else if (wait_sw) m_st = 1;
                   else m_pc = (m_pc + 1) % 16;
                1: if (m_clean != 0) m_st = 2;
                2: if (m_clean == 0) begin m_st = 0; m_pc = (m_pc + 1) % 16; end
                default: ;
            endcase
            m11 = (m11 + 1) % 12;
            if (DEB) begin
                if (int'(s) != m_clean) begin
                    m_run++;
                    if (m_run == DB) begin m_clean = int'(s); m_run = 0; end
                end else begin
                    m_run = 0;
                end
            end
            void'(pipe.pop_front());
            pipe.push_back(sw8);
            if (!DEB) m_clean = int'(pipe[0]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("pc11", 32'(pc11), 32'(m11));
        chk("state11", 32'(state11), 32'd0);
        chk("stall11", 32'(stall11), 32'd0);
        chk("clean11", 32'(clean11), 32'(m_clean));
    endtask

    task automatic compare_model();
        chk("rnd_pc", 32'(pc), 32'(m_pc));
        chk("rnd_state", 32'(state), 32'(m_st));
        chk("rnd_clean", 32'(clean), 32'(m_clean));
        chk("rnd_stall", 32'(stall), 32'((m_st != 0) || halt || wait_sw));
    endtask

    typedef struct {
        bit rst; bit sw; bit wt; bit hl;
        int n;
        int pc; int st; int cl; int stl;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit rst, bit sw, bit wt, bit hl, int n,
                                int epc, int est, int ecl, int estl);
        vec_t v;
        v.rst = rst; v.sw = sw; v.wt = wt; v.hl = hl; v.n = n;
        v.pc = epc; v.st = est; v.cl = ecl; v.stl = estl;
        return v;
    endfunction

    initial begin
        tbl.push_back(mk(1, 0, 0, 0, 2,       0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 5,       5, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 1,       5, 1, 0, 1));
        tbl.push_back(mk(0, 1, 0, 0, LAT,     5, 1, 1, 1));
        tbl.push_back(mk(0, 1, 0, 0, 1,       5, 2, 1, 1));
        tbl.push_back(mk(0, 1, 0, 0, 5,       5, 2, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0, LAT,     5, 2, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 1,       6, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 3,       9, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 1,       9, 3, 0, 1));
        tbl.push_back(mk(0, 1, 0, 0, 20,      9, 3, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 30,      9, 3, 0, 1));
        tbl.push_back(mk(1, 1, 0, 0, 1,       0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 7,       7, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 1,       7, 1, 0, 1));
        tbl.push_back(mk(0, 1, 0, 0, LAT + 1, 7, 2, 1, 1));
        tbl.push_back(mk(1, 1, 0, 0, 1,       0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 15,      15, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1,       0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 4,       4, 0, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            reset = tbl[i].rst; sw8 = tbl[i].sw; wait_sw = tbl[i].wt; halt = tbl[i].hl;
            repeat (tbl[i].n) tick();
            chk($sformatf("vec%0d.pc", i), 32'(pc), 32'(tbl[i].pc));
            chk($sformatf("vec%0d.state", i), 32'(state), 32'(tbl[i].st));
            chk($sformatf("vec%0d.clean", i), 32'(clean), 32'(tbl[i].cl));
            chk($sformatf("vec%0d.stall", i), 32'(stall), 32'(tbl[i].stl));
        end

        // Exact switch latency from the first capturing edge.
        reset = 1'b1; sw8 = 1'b0; wait_sw = 1'b0; halt = 1'b0;
        tick();
        reset = 1'b0; wait_sw = 1'b1;
        tick();
        chk("lat_enter_wait", 32'(state), 32'd1);
        wait_sw = 1'b0; sw8 = 1'b1;
        repeat (LAT - 1) tick();
        chk("lat_before", 32'(clean), 32'd0);
        tick();
        chk("lat_at", 32'(clean), 32'd1);
        chk("lat_state_hold", 32'(state), 32'd1);
        tick();
        chk("lat_state_release", 32'(state), 32'd2);

`ifdef PC_DEBOUNCE_EN
        // A 3-cycle glitch is filtered; a 4-cycle level gets through at edge 6.
        reset = 1'b1; sw8 = 1'b0;
        tick();
        reset = 1'b0; wait_sw = 1'b1;
        tick();
        wait_sw = 1'b0; sw8 = 1'b1;
        repeat (3) tick();
        sw8 = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("glitch_clean", 32'(clean), 32'd0);
            chk("glitch_state", 32'(state), 32'd1);
        end
        sw8 = 1'b1;
        repeat (5) tick();
        chk("db_edge5", 32'(clean), 32'd0);
        tick();
        chk("db_edge6", 32'(clean), 32'd1);
`endif

        reset = 1'b1; sw8 = 1'b0; wait_sw = 1'b0; halt = 1'b0;
        tick();
        compare_model();
        for (int k = 0; k < 1500; k++) begin
            reset   = ($urandom_range(0, 59) == 0);
            halt    = ($urandom_range(0, 29) == 0);
            wait_sw = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 5) == 0) sw8 = ~sw8;
            tick();
            compare_model();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter sequencer for the picoMIPS control path: holds the instruction address driven into program memory and decides each cycle whether it advances, waits on an operator switch handshake, or halts. It sits directly upstream of program memory and the decoder. It takes the decoder's per-instruction wait/halt requests plus the raw SW[8] switch, and produces the next fetch address and a clean switch level for the decoder.

## Interface
- P_SIZE, 4, program-address width in bits
- PROG_LAST, 2**P_SIZE-1, last valid program address; PC wraps from here to 0
- DB_COUNT, 50000, consecutive cycles a changed switch level must persist before sw8_clean follows (debounce builds only)
- DB_WIDTH, 16, debounce counter width; must hold DB_COUNT-1
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- SW8  input  1  raw, asynchronous operator switch
- wait_sw  input  1  current instruction requires a press-then-release handshake on SW8 before PC advances
- halt  input  1  current instruction is a halt
- PCout  output  P_SIZE  registered fetch address
- sw8_clean  output  1  synchronised (and optionally debounced) SW8 level, fed to decoder SW8 input
- stall  output  1  high in any cycle where PCout will not advance at the next edge
- state  output  2  current FSM state, for debug and LEDs

## Operation
- Reset values: PCout=0, state=RUN, sw8_clean=0, synchroniser flops=0, debounce counter=0. stall follows from these and the inputs.
- Reset dominates every other input on the edge where it is sampled high, including mid-handshake and in HALTED.
- Synchroniser: two flops in series on SW8 produce sw8_sync.
- FSM states: RUN=0, WAIT_PRESS=1, WAIT_RELEASE=2, HALTED=3.
- RUN with halt=1 goes to HALTED and PC holds. halt wins when halt and wait_sw are both 1.
- RUN with wait_sw=1 and halt=0 goes to WAIT_PRESS and PC holds.
- RUN with neither set: PC <= PC+1, or 0 if PC==PROG_LAST.
- WAIT_PRESS with sw8_clean=1 goes to WAIT_RELEASE; otherwise it stays. PC holds.
- WAIT_RELEASE with sw8_clean=0 goes to RUN, and PC advances on that same edge, with wrap applied. Otherwise it stays and PC holds.
- HALTED is left only by reset. PC holds.
- wait_sw and halt are ignored outside RUN. The instruction is stable because PC is held.
- stall = (state!=RUN) | halt | wait_sw, evaluated while in RUN. stall is combinational.
- PC arithmetic is modulo P_SIZE bits. PROG_LAST < 2**P_SIZE-1 truncates the program space.

## Timing
- PCout changes only on clock edges. Program memory and decoder are combinational from PCout, so wait_sw and halt are valid in the same cycle.
- Free-running: one new address per cycle.
- SW8 to sw8_sync: 2 edges.
- Debounce on: counter increments on each edge where sw8_sync != sw8_clean. It clears on any edge where they are equal. When the counter equals DB_COUNT-1 and the levels still differ, sw8_clean toggles and the counter clears. sw8_clean therefore changes at edge 2+DB_COUNT after the first edge that captures the new level. A glitch shorter than DB_COUNT cycles never reaches sw8_clean.
- Minimum handshake: entry edge, then ≥1 cycle in WAIT_PRESS, then ≥1 cycle in WAIT_RELEASE, then PC advances.

## Configuration
- PC_DEBOUNCE_EN defined: the debounce counter is present with the behaviour above.
- PC_DEBOUNCE_EN undefined: sw8_clean = sw8_sync, no counter, and DB_COUNT/DB_WIDTH are unused. All FSM behaviour is identical.

## Structure
- picomips_pkg holds typedef enum logic [1:0] pcseq_state_t (RUN, WAIT_PRESS, WAIT_RELEASE, HALTED) and the default DB_COUNT constant.
- One sub-module, sw_debounce: the 2-flop synchroniser plus the macro-controlled debounce counter, with output sw8_clean. The FSM and PC register live in pc_sequencer.

## Test plan
Bench uses DB_COUNT=4 with PC_DEBOUNCE_EN defined, and one regression without it.
- Reset, then wait_sw=halt=0 for 20 cycles -> PCout 0,1,…,15,0,1,2,3; stall=0 throughout.
- At PCout=5 assert wait_sw. Pulse SW8 high for 10 cycles, then low -> state 1 then 2; PCout=5 until sw8_clean falls, then 6 on that edge; stall=1 while waiting.
- SW8 glitch high for 3 cycles while in WAIT_PRESS -> sw8_clean stays 0 and state stays 1. Hold high 4+ cycles -> sw8_clean rises at edge 6 after capture.
- At PCout=9 assert halt and wait_sw together -> state=3, PCout frozen at 9 for 50 cycles regardless of SW8.
- Assert reset while in WAIT_RELEASE with PCout=7 -> next edge gives PCout=0, state=0, sw8_clean=0.
- PROG_LAST=11 build -> PCout sequence wraps 11 to 0. Without PC_DEBOUNCE_EN, a SW8 rise reaches sw8_clean at exactly edge 2.
